// File: rtl/log_export_condense_pkg.sv
// Shared VR log types: stored/wire entry headers, FSM state encoding and the
// payload line-count helper used by both the export and install paths.
package log_export_condense_pkg;

  localparam int INT_W          = 32;
  localparam int NOC_DATA_BYTES = 64;
  localparam int NOC_PADBYTES_W = $clog2(NOC_DATA_BYTES);
  localparam int LOG_STATE_W    = 8;
  localparam int PAYLOAD_LEN_W  = 16;

  typedef struct packed {
    logic [INT_W-1:0]         view;
    logic [INT_W-1:0]         op_num;
    logic [LOG_STATE_W-1:0]   log_entry_state;
    logic [INT_W-1:0]         payload_addr;
    logic [PAYLOAD_LEN_W-1:0] payload_len;
  } log_entry_hdr;

  // total_size counts the wire header line itself plus the payload bytes
  typedef struct packed {
    logic [INT_W-1:0]       view;
    logic [INT_W-1:0]       op_num;
    logic [LOG_STATE_W-1:0] log_entry_state;
    logic [INT_W-1:0]       total_size;
  } wire_log_entry_hdr;

  localparam logic [2:0] ST_READY         = 3'd0;
  localparam logic [2:0] ST_RD_HDR_REQ    = 3'd1;
  localparam logic [2:0] ST_RD_HDR_RESP   = 3'd2;
  localparam logic [2:0] ST_SEND_WIRE_HDR = 3'd3;
  localparam logic [2:0] ST_RD_DATA_REQ   = 3'd4;
  localparam logic [2:0] ST_RD_DATA_RESP  = 3'd5;
  localparam logic [2:0] ST_NEXT_ENTRY    = 3'd6;
  localparam logic [2:0] ST_DONE          = 3'd7;

  function automatic logic [PAYLOAD_LEN_W-1:0] calc_payload_lines(
    input logic [PAYLOAD_LEN_W-1:0] payload_len
  );
    logic [PAYLOAD_LEN_W:0] rounded;
    rounded = {1'b0, payload_len} + (PAYLOAD_LEN_W+1)'(NOC_DATA_BYTES - 1);
    return PAYLOAD_LEN_W'(rounded >> NOC_PADBYTES_W);
  endfunction

endpackage

// File: rtl/log_export_condense.sv
// Walks the VR log from a requested op to the tail and streams wire log entries
// (header line + payload lines). Define LOG_EXPORT_LIMIT_EN to cap the entry count.
module log_export_condense
  import log_export_condense_pkg::*;
#(
  parameter int NOC_DATA_W      = 512,
  parameter int LOG_HDR_DEPTH_W = 10,
  parameter int LOG_DEPTH_W     = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_log_export,
  input  logic [INT_W-1:0]           export_first_op,
  input  logic [INT_W-1:0]           log_first_op,
  input  logic [LOG_HDR_DEPTH_W:0]   log_hdr_ptr,
  input  logic [LOG_HDR_DEPTH_W:0]   log_tail_ptr,
`ifdef LOG_EXPORT_LIMIT_EN
  input  logic [LOG_HDR_DEPTH_W:0]   export_max_entries,
`endif
  output logic                       export_log_hdr_mem_rd_req_val,
  output logic [LOG_HDR_DEPTH_W-1:0] export_log_hdr_mem_rd_req_addr,
  input  logic                       log_hdr_mem_export_rd_req_rdy,
  input  logic                       log_hdr_mem_export_rd_resp_val,
  input  log_entry_hdr               log_hdr_mem_export_rd_resp_data,
  output logic                       export_log_hdr_mem_rd_resp_rdy,
  output logic                       export_log_data_mem_rd_req_val,
  output logic [LOG_DEPTH_W-1:0]     export_log_data_mem_rd_req_addr,
  input  logic                       log_data_mem_export_rd_req_rdy,
  input  logic                       log_data_mem_export_rd_resp_val,
  input  logic [NOC_DATA_W-1:0]      log_data_mem_export_rd_resp_data,
  output logic                       export_log_data_mem_rd_resp_rdy,
  output logic                       export_dst_val,
  output logic [NOC_DATA_W-1:0]      export_dst_data,
  output logic                       export_dst_last,
  output logic [NOC_PADBYTES_W-1:0]  export_dst_padbytes,
  input  logic                       dst_export_rdy,
  output logic                       export_done_val,
  output logic [LOG_HDR_DEPTH_W:0]   export_done_entries,
  input  logic                       dst_export_done_rdy
);

  localparam int PTR_W = LOG_HDR_DEPTH_W + 1;

  logic [2:0]               state;
  logic [PTR_W-1:0]         cur_ptr;
  logic [PTR_W-1:0]         entries_left;
  logic [PTR_W-1:0]         entries_sent;
  logic [LOG_DEPTH_W-1:0]   data_ptr;
  logic [PAYLOAD_LEN_W-1:0] lines_left;
  logic [INT_W-1:0]         hdr_view;
  logic [INT_W-1:0]         hdr_op_num;
  logic [LOG_STATE_W-1:0]   hdr_entry_state;
  logic [PAYLOAD_LEN_W-1:0] hdr_len;

  // Start-time range computation; pointers are modular with the wrap bit.
  logic [INT_W-1:0] op_offset;
  logic [PTR_W-1:0] first_ptr;
  logic [PTR_W-1:0] log_span;
  logic [PTR_W-1:0] avail_entries;
  logic [PTR_W-1:0] start_entries;
  logic             out_of_range;

  assign op_offset     = export_first_op - log_first_op;
  assign first_ptr     = log_hdr_ptr + op_offset[PTR_W-1:0];
  assign log_span      = log_tail_ptr - log_hdr_ptr;
  assign out_of_range  = (export_first_op < log_first_op) || (op_offset > INT_W'(log_span));
  assign avail_entries = out_of_range ? '0 : (log_tail_ptr - first_ptr);

`ifdef LOG_EXPORT_LIMIT_EN
  assign start_entries = ((export_max_entries != '0) && (export_max_entries < avail_entries))
                       ? export_max_entries : avail_entries;
`else
  assign start_entries = avail_entries;
`endif

  logic                      final_entry;
  logic [PAYLOAD_LEN_W-1:0]  total_lines;
  logic [INT_W-1:0]          padded_len;
  logic [NOC_PADBYTES_W-1:0] pad_bytes;
  wire_log_entry_hdr         wire_hdr;

  assign final_entry = (entries_left == PTR_W'(1));
  assign total_lines = calc_payload_lines(hdr_len);
  assign padded_len  = INT_W'(total_lines) * INT_W'(NOC_DATA_BYTES);
  assign pad_bytes   = NOC_PADBYTES_W'(padded_len - INT_W'(hdr_len));

  assign wire_hdr.view            = hdr_view;
  assign wire_hdr.op_num          = hdr_op_num;
  assign wire_hdr.log_entry_state = hdr_entry_state;
  assign wire_hdr.total_size      = INT_W'(NOC_DATA_BYTES) + INT_W'(hdr_len);

  assign export_log_hdr_mem_rd_req_val   = (state == ST_RD_HDR_REQ);
  assign export_log_hdr_mem_rd_req_addr  = cur_ptr[LOG_HDR_DEPTH_W-1:0];
  assign export_log_hdr_mem_rd_resp_rdy  = (state == ST_RD_HDR_RESP);
  assign export_log_data_mem_rd_req_val  = (state == ST_RD_DATA_REQ);
  assign export_log_data_mem_rd_req_addr = data_ptr;
  assign export_log_data_mem_rd_resp_rdy = (state == ST_RD_DATA_RESP) && dst_export_rdy;
  assign export_done_val                 = (state == ST_DONE);
  assign export_done_entries             = (state == ST_DONE) ? entries_sent : '0;

  // Payload lines pass straight through; dst_val follows the memory, never rdy.
  always_comb begin
    export_dst_val      = 1'b0;
    export_dst_data     = '0;
    export_dst_last     = 1'b0;
    export_dst_padbytes = '0;
    case (state)
      ST_SEND_WIRE_HDR: begin
        export_dst_val  = 1'b1;
        export_dst_data = NOC_DATA_W'(wire_hdr);
        export_dst_last = final_entry && (lines_left == '0);
      end
      ST_RD_DATA_RESP: begin
        export_dst_val  = log_data_mem_export_rd_resp_val;
        export_dst_data = log_data_mem_export_rd_resp_data;
        if (final_entry && (lines_left == PAYLOAD_LEN_W'(1))) begin
          export_dst_last     = 1'b1;
          export_dst_padbytes = pad_bytes;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_READY;
      cur_ptr         <= '0;
      entries_left    <= '0;
      entries_sent    <= '0;
      data_ptr        <= '0;
      lines_left      <= '0;
      hdr_view        <= '0;
      hdr_op_num      <= '0;
      hdr_entry_state <= '0;
      hdr_len         <= '0;
    end else begin
      case (state)
        ST_READY: if (start_log_export) begin
          cur_ptr      <= first_ptr;
          entries_left <= start_entries;
          entries_sent <= '0;
          state        <= (start_entries != '0) ? ST_RD_HDR_REQ : ST_DONE;
        end
        ST_RD_HDR_REQ: if (log_hdr_mem_export_rd_req_rdy) state <= ST_RD_HDR_RESP;
        ST_RD_HDR_RESP: if (log_hdr_mem_export_rd_resp_val) begin
          hdr_view        <= log_hdr_mem_export_rd_resp_data.view;
          hdr_op_num      <= log_hdr_mem_export_rd_resp_data.op_num;
          hdr_entry_state <= log_hdr_mem_export_rd_resp_data.log_entry_state;
          hdr_len         <= log_hdr_mem_export_rd_resp_data.payload_len;
          data_ptr        <= LOG_DEPTH_W'(log_hdr_mem_export_rd_resp_data.payload_addr);
          lines_left      <= calc_payload_lines(log_hdr_mem_export_rd_resp_data.payload_len);
          state           <= ST_SEND_WIRE_HDR;
        end
        ST_SEND_WIRE_HDR: if (dst_export_rdy)
          state <= (lines_left != '0) ? ST_RD_DATA_REQ : ST_NEXT_ENTRY;
        ST_RD_DATA_REQ: if (log_data_mem_export_rd_req_rdy) state <= ST_RD_DATA_RESP;
        ST_RD_DATA_RESP: if (log_data_mem_export_rd_resp_val && dst_export_rdy) begin
          if (lines_left == PAYLOAD_LEN_W'(1)) begin
            state <= ST_NEXT_ENTRY;
          end else begin
            data_ptr   <= data_ptr + 1'b1;
            lines_left <= lines_left - 1'b1;
            state      <= ST_RD_DATA_REQ;
          end
        end
        ST_NEXT_ENTRY: begin
          cur_ptr      <= cur_ptr + 1'b1;
          entries_left <= entries_left - 1'b1;
          entries_sent <= entries_sent + 1'b1;
          state        <= final_entry ? ST_DONE : ST_RD_HDR_REQ;
        end
        ST_DONE: if (dst_export_done_rdy) state <= ST_READY;
        default: state <= ST_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_log_export_condense.sv
// Randomized bench for log_export_condense: memory responders with stalls, a
// reference model that builds the expected flit stream from the log contents.
`timescale 1ns/1ps
module tb_log_export_condense;
  import log_export_condense_pkg::*;

  localparam int DW = 512;
  localparam int HW = 10;
  localparam int LW = 12;
  localparam int PW = HW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                      start_log_export;
  logic [INT_W-1:0]          export_first_op, log_first_op;
  logic [PW-1:0]             log_hdr_ptr, log_tail_ptr;
`ifdef LOG_EXPORT_LIMIT_EN
  logic [PW-1:0]             export_max_entries;
`endif
  logic                      hdr_req_val, hdr_req_rdy, hdr_resp_val, hdr_resp_rdy;
  logic [HW-1:0]             hdr_req_addr;
  log_entry_hdr              hdr_resp_data;
  logic                      data_req_val, data_req_rdy, data_resp_val, data_resp_rdy;
  logic [LW-1:0]             data_req_addr;
  logic [DW-1:0]             data_resp_data;
  logic                      dst_val, dst_last, dst_rdy;
  logic [DW-1:0]             dst_data;
  logic [NOC_PADBYTES_W-1:0] dst_pad;
  logic                      done_val, done_rdy;
  logic [PW-1:0]             done_entries;

  log_export_condense #(.NOC_DATA_W(DW), .LOG_HDR_DEPTH_W(HW), .LOG_DEPTH_W(LW)) dut (
    .clk(clk), .rst(rst),
    .start_log_export(start_log_export),
    .export_first_op(export_first_op), .log_first_op(log_first_op),
    .log_hdr_ptr(log_hdr_ptr), .log_tail_ptr(log_tail_ptr),
`ifdef LOG_EXPORT_LIMIT_EN
    .export_max_entries(export_max_entries),
`endif
    .export_log_hdr_mem_rd_req_val(hdr_req_val),
    .export_log_hdr_mem_rd_req_addr(hdr_req_addr),
    .log_hdr_mem_export_rd_req_rdy(hdr_req_rdy),
    .log_hdr_mem_export_rd_resp_val(hdr_resp_val),
    .log_hdr_mem_export_rd_resp_data(hdr_resp_data),
    .export_log_hdr_mem_rd_resp_rdy(hdr_resp_rdy),
    .export_log_data_mem_rd_req_val(data_req_val),
    .export_log_data_mem_rd_req_addr(data_req_addr),
    .log_data_mem_export_rd_req_rdy(data_req_rdy),
    .log_data_mem_export_rd_resp_val(data_resp_val),
    .log_data_mem_export_rd_resp_data(data_resp_data),
    .export_log_data_mem_rd_resp_rdy(data_resp_rdy),
    .export_dst_val(dst_val), .export_dst_data(dst_data),
    .export_dst_last(dst_last), .export_dst_padbytes(dst_pad),
    .dst_export_rdy(dst_rdy),
    .export_done_val(done_val), .export_done_entries(done_entries),
    .dst_export_done_rdy(done_rdy)
  );

  log_entry_hdr  hdr_mem  [0:1023];
  logic [DW-1:0] data_mem [0:4095];

  typedef struct {
    logic [DW-1:0]             data;
    logic                      last;
    logic [NOC_PADBYTES_W-1:0] pad;
  } flit_t;
  flit_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Responder / monitor state
  int            stall_pct = 30;
  int            hdr_delay = -1, data_delay = -1;
  logic [HW-1:0] hdr_addr_q;
  logic [LW-1:0] data_addr_q;
  bit            hs_hdr_req, hs_hdr_resp, hs_data_req, hs_data_resp;
  bit            done_seen;
  logic [PW-1:0] done_obs;
  int            flits_seen = 0;

  initial begin
    flit_t f;
    hdr_req_rdy = 0; hdr_resp_val = 0; hdr_resp_data = '0;
    data_req_rdy = 0; data_resp_val = 0; data_resp_data = '0;
    dst_rdy = 0; done_rdy = 0;
    forever begin
      @(negedge clk);
      if (hs_hdr_req)   hdr_delay = $urandom_range(0, 2);
      if (hs_hdr_resp)  hdr_resp_val = 0;
      if (hs_data_req)  data_delay = $urandom_range(0, 2);
      if (hs_data_resp) data_resp_val = 0;
      if (hdr_delay == 0 && !hdr_resp_val) begin
        hdr_resp_val = 1; hdr_resp_data = hdr_mem[hdr_addr_q]; hdr_delay = -1;
      end else if (hdr_delay > 0) hdr_delay--;
      if (data_delay == 0 && !data_resp_val) begin
        data_resp_val = 1; data_resp_data = data_mem[data_addr_q]; data_delay = -1;
      end else if (data_delay > 0) data_delay--;
      hdr_req_rdy  = ($urandom_range(0, 99) >= stall_pct);
      data_req_rdy = ($urandom_range(0, 99) >= stall_pct);
      dst_rdy      = ($urandom_range(0, 99) >= stall_pct);
      done_rdy     = ($urandom_range(0, 99) >= stall_pct);
      #1;
      if (rst) begin
        hdr_delay = -1; data_delay = -1; hdr_resp_val = 0; data_resp_val = 0;
        hs_hdr_req = 0; hs_hdr_resp = 0; hs_data_req = 0; hs_data_resp = 0;
        exp_q.delete();
      end else begin
        hs_hdr_req   = hdr_req_val && hdr_req_rdy;
        hs_hdr_resp  = hdr_resp_val && hdr_resp_rdy;
        hs_data_req  = data_req_val && data_req_rdy;
        hs_data_resp = data_resp_val && data_resp_rdy;
        if (hs_hdr_req)  hdr_addr_q  = hdr_req_addr;
        if (hs_data_req) data_addr_q = data_req_addr;
        if (dst_val && dst_rdy) begin
          flits_seen++;
          if (exp_q.size() == 0) check_val("flit_expected", DW'(exp_q.size()), DW'(1));
          else begin
            f = exp_q.pop_front();
            check_val("flit_data", dst_data, f.data);
            check_val("flit_last", DW'(dst_last), DW'(f.last));
            check_val("flit_pad", DW'(dst_pad), DW'(f.pad));
          end
        end
        if (done_val && done_rdy) begin
          done_seen = 1; done_obs = done_entries;
        end
      end
    end
  end

  task automatic fill_entry(input logic [PW-1:0] ptr, input int op, input int len, input int addr);
    log_entry_hdr h;
    h.view            = $urandom;
    h.op_num          = op;
    h.log_entry_state = 8'($urandom);
    h.payload_addr    = addr;
    h.payload_len     = 16'(len);
    hdr_mem[ptr[HW-1:0]] = h;
  endtask

  // Expected stream derived from the log contents and the export rules.
  task automatic build_expected(input logic [PW-1:0] hd, input int lfo, input logic [PW-1:0] tl,
                                input int efo, input int maxe, output int n);
    int span, off, lines;
    logic [PW-1:0] p;
    log_entry_hdr h;
    flit_t f;
    span = int'(PW'(tl - hd));
    off  = efo - lfo;
    n    = (efo < lfo || off > span) ? 0 : span - off;
    if (maxe != 0 && maxe < n) n = maxe;
    for (int e = 0; e < n; e++) begin
      p = hd + PW'(off + e);
      h = hdr_mem[p[HW-1:0]];
      lines = (int'(h.payload_len) + 63) / 64;
      f.data = '0;
      f.data[103:0] = {h.view, h.op_num, h.log_entry_state, 32'(64 + int'(h.payload_len))};
      f.last = (e == n - 1) && (lines == 0);
      f.pad  = '0;
      exp_q.push_back(f);
      for (int l = 0; l < lines; l++) begin
        f.data = data_mem[(int'(h.payload_addr) + l) % 4096];
        f.last = (e == n - 1) && (l == lines - 1);
        f.pad  = f.last ? NOC_PADBYTES_W'(lines * 64 - int'(h.payload_len)) : '0;
        exp_q.push_back(f);
      end
    end
  endtask

  task automatic run_export(input string name, input logic [PW-1:0] hd, input int lfo,
                            input logic [PW-1:0] tl, input int efo, input int maxe,
                            input bit restart_pulse);
    int n, cyc, base;
    build_expected(hd, lfo, tl, efo, maxe, n);
    base = flits_seen;
    done_seen = 0;
    @(negedge clk);
    log_hdr_ptr = hd; log_tail_ptr = tl; log_first_op = lfo; export_first_op = efo;
`ifdef LOG_EXPORT_LIMIT_EN
    export_max_entries = PW'(maxe);
`endif
    start_log_export = 1;
    cyc = 0;
    while (!done_seen && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start_log_export = (restart_pulse && cyc == 5);
      if (start_log_export) export_first_op = efo + 1;
    end
    start_log_export = 0;
    check_val({name, "_done_timeout"}, DW'(done_seen), DW'(1));
    check_val({name, "_done_entries"}, DW'(done_obs), DW'(n));
    check_val({name, "_flits_left"}, DW'(exp_q.size()), DW'(0));
    $display("export %s: head=%0d tail=%0d first_op=%0d export_op=%0d entries=%0d flits=%0d",
             name, hd, tl, lfo, efo, n, flits_seen - base);
  endtask

  task automatic check_idle(input string name);
    check_val({name, "_dst_val"},  DW'(dst_val), DW'(0));
    check_val({name, "_dst_last"}, DW'(dst_last), DW'(0));
    check_val({name, "_done_val"}, DW'(done_val), DW'(0));
    check_val({name, "_hdr_req"},  DW'(hdr_req_val), DW'(0));
    check_val({name, "_data_req"}, DW'(data_req_val), DW'(0));
  endtask

  initial begin
    int span, lfo, efo, maxe, cyc, base;
    logic [PW-1:0] hd;
    start_log_export = 0; export_first_op = 0; log_first_op = 0;
    log_hdr_ptr = 0; log_tail_ptr = 0;
`ifdef LOG_EXPORT_LIMIT_EN
    export_max_entries = 0;
`endif
    for (int i = 0; i < 1024; i++) hdr_mem[i] = '0;
    for (int a = 0; a < 4096; a++)
      for (int w = 0; w < DW / 32; w++) data_mem[a][w*32 +: 32] = $urandom;

    repeat (4) @(negedge clk);
    check_idle("reset");
    check_val("reset_pad", DW'(dst_pad), DW'(0));
    check_val("reset_data", dst_data, DW'(0));
    check_val("reset_done_entries", DW'(done_entries), DW'(0));
    rst = 0;

    // Payloads 0, 64, 100 bytes; the 100-byte one wraps the data memory.
    fill_entry(0, 10, 0, 100);
    fill_entry(1, 11, 64, 200);
    fill_entry(2, 12, 100, 4095);
    run_export("full", 0, 10, 3, 10, 0, 1);
    run_export("suffix", 0, 10, 3, 12, 0, 0);
    run_export("at_tail", 0, 10, 3, 13, 0, 0);
    run_export("before_head", 0, 10, 3, 5, 0, 0);

    // Header pointer wrap across 1023 -> 0
    for (int k = 0; k < 4; k++) fill_entry(PW'(1022 + k), 500 + k, $urandom_range(0, 200), 4090 + k);
    run_export("wrap", 1022, 500, 1026, 500, 0, 0);
    run_export("wrap_mid", 1022, 500, 1026, 502, 0, 0);

    for (int t = 0; t < 25; t++) begin
      stall_pct = $urandom_range(0, 60);
      hd   = PW'($urandom_range(0, 2047));
      span = $urandom_range(0, 6);
      lfo  = $urandom_range(1000, 2000);
      for (int k = 0; k < span; k++)
        fill_entry(hd + PW'(k), lfo + k, $urandom_range(0, 300),
                   ($urandom_range(0, 1) == 1) ? $urandom_range(4085, 4095) : $urandom_range(0, 4095));
      efo  = lfo + $urandom_range(0, span + 2) - 1;
      maxe = 0;
`ifdef LOG_EXPORT_LIMIT_EN
      maxe = $urandom_range(0, 4);
`endif
      run_export("random", hd, lfo, hd + PW'(span), efo, maxe, 0);
    end

    // Reset in the middle of a payload
    stall_pct = 20;
    for (int k = 0; k < 3; k++) fill_entry(PW'(5 + k), k, 300, 64 * k);
    build_expected(5, 0, 8, 0, 0, span);
    base = flits_seen;
    @(negedge clk);
    log_hdr_ptr = 5; log_tail_ptr = 8; log_first_op = 0; export_first_op = 0;
`ifdef LOG_EXPORT_LIMIT_EN
    export_max_entries = 0;
`endif
    start_log_export = 1;
    @(negedge clk);
    start_log_export = 0;
    cyc = 0;
    while (flits_seen < base + 3 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_val("midrst_progress", DW'(flits_seen >= base + 3), DW'(1));
    rst = 1;
    @(negedge clk);
    rst = 0;
    #2;
    check_idle("after_rst");
    $display("export midrst: reset after %0d flits", flits_seen - base);
    run_export("post_rst", 5, 0, 8, 1, 0, 0);

`ifdef LOG_EXPORT_LIMIT_EN
    for (int k = 0; k < 5; k++) fill_entry(PW'(k), 50 + k, 70, 300 + 4 * k);
    run_export("limit", 0, 50, 5, 50, 2, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/log_export_condense.md
Name: log_export_condense

Overview:
- Transmit-side counterpart of the log install path.
- Walks the local VR log from a requested op number up to the log tail. For each entry it reads the header from log hdr mem and the payload lines from log data mem.
- Emits a NoC-width stream of wire log entries: one wire header line, then the payload lines. Used to ship log suffixes in DoViewChange/StartView/state-transfer messages.
- Sits between the log memories and the message builder; the install block consumes this stream format.

Parameters:
- NOC_DATA_W, 512, stream/data-mem line width.
- LOG_HDR_DEPTH_W, 10, log2 of header mem depth.
- LOG_DEPTH_W, 12, log2 of data mem depth (lines).
- INT_W, 32, op/view number width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start_log_export  in  1  one-cycle start pulse; sampled only in READY
- export_first_op  in  INT_W  first op to export
- log_first_op  in  INT_W  op number stored at log_hdr_ptr
- log_hdr_ptr  in  LOG_HDR_DEPTH_W+1  log head pointer (wrap bit included)
- log_tail_ptr  in  LOG_HDR_DEPTH_W+1  log tail pointer
- export_log_hdr_mem_rd_req_val / _addr[LOG_HDR_DEPTH_W-1:0]  out ; log_hdr_mem_export_rd_req_rdy  in
- log_hdr_mem_export_rd_resp_val  in ; log_hdr_mem_export_rd_resp_data  in  log_entry_hdr ; export_log_hdr_mem_rd_resp_rdy  out
- export_log_data_mem_rd_req_val / _addr[LOG_DEPTH_W-1:0]  out ; log_data_mem_export_rd_req_rdy  in
- log_data_mem_export_rd_resp_val  in ; log_data_mem_export_rd_resp_data  in  NOC_DATA_W ; export_log_data_mem_rd_resp_rdy  out
- export_dst_val  out  1 ; export_dst_data  out  NOC_DATA_W ; export_dst_last  out  1 ; export_dst_padbytes  out  NOC_PADBYTES_W ; dst_export_rdy  in  1
- export_done_val  out  1 ; export_done_entries  out  LOG_HDR_DEPTH_W+1 ; dst_export_done_rdy  in  1

Behaviour:
- Reset: rst synchronous, active-high; clock clk. State goes to READY. All val/rdy outputs and export_dst_last are 0. Data outputs, padbytes and counters are 0.
- Latched on start:
  - first_ptr = log_hdr_ptr + (export_first_op - log_first_op).
  - cur_ptr = first_ptr; tail_reg = log_tail_ptr.
  - entries_left = tail_reg - first_ptr (width LOG_HDR_DEPTH_W+1, modular); entries_sent = 0.
- Out-of-range request: if export_first_op < log_first_op, or (export_first_op - log_first_op) > (tail - head), set entries_left = 0.
- Address arithmetic: hdr mem address = cur_ptr[LOG_HDR_DEPTH_W-1:0]; data address wraps modulo 2^LOG_DEPTH_W.
- States:
  - READY: on start, go to RD_HDR_REQ if entries_left != 0, else DONE.
  - RD_HDR_REQ: rd_req_val=1; on req_rdy go to RD_HDR_RESP.
  - RD_HDR_RESP: resp_rdy=1; on resp_val latch the header, set data_ptr = payload_addr and lines_left = ceil(payload_len / NOC_DATA_BYTES), then go to SEND_WIRE_HDR.
  - SEND_WIRE_HDR: dst_val=1. Data = packed wire_log_entry_hdr: view, op_num, log_entry_state, total_size = NOC_DATA_BYTES + payload_len. last = (entries_left==1 && lines_left==0); padbytes = 0. On rdy go to RD_DATA_REQ if lines_left != 0, else NEXT_ENTRY.
  - RD_DATA_REQ: data rd_req_val=1; on rdy go to RD_DATA_RESP.
  - RD_DATA_RESP: dst_val = resp_val; resp_rdy = dst_export_rdy; data passes through unmodified.
    - On a handshake with lines_left==1 (final line of the entry): last = (entries_left==1); padbytes = lines*NOC_DATA_BYTES - payload_len when last, else 0. Go to NEXT_ENTRY.
    - On any other handshake: data_ptr+1, lines_left-1, go to RD_DATA_REQ.
  - NEXT_ENTRY: cur_ptr+1, entries_left-1, entries_sent+1; go to RD_HDR_REQ if entries_left != 1, else DONE.
  - DONE: export_done_val=1, export_done_entries = entries_sent; on rdy go to READY.
- Flow and ordering:
  - Only one memory read is outstanding at a time.
  - dst_val never depends on dst_export_rdy.
  - Header flit latency after start: at least 3 cycles with ideal memories.
- Boundaries:
  - Zero-length payload: header flit only.
  - Pointer wrap at 2^LOG_HDR_DEPTH_W: handled by the modular pointer.
  - start while not READY: ignored.
  - Reset mid-stream: abandons the stream immediately, with no last flit.

Optional Feature:
- Macro LOG_EXPORT_LIMIT_EN.
- Enabled: adds input export_max_entries[LOG_HDR_DEPTH_W:0]. At start, entries_left = min(computed, export_max_entries); 0 means no limit.
- Disabled: no port; the full suffix to the tail is always exported.

Decomposition:
- Shared VR log package holds: log_entry_hdr, wire_log_entry_hdr, NOC_DATA_BYTES, NOC_PADBYTES_W, INT_W and the state enum.
- Line-count helper function (ceil of payload_len / NOC_DATA_BYTES) lives in the package; install reuses it.
- No sub-module; a single FSM plus datapath.

Test Plan:
- Log head=0, first_op=10, tail=3; export_first_op=10; payloads 0, 64 and 100 bytes.
  - Expect flits: H, H D, H D D.
  - Last flit on the final D, padbytes=28.
  - done_entries=3.
- export_first_op=12, same log -> header+2 data lines only, done_entries=1.
- export_first_op=13 (== tail op) and export_first_op=5 (before head) -> no flits, done_val with 0.
- Head=1022, tail=1026 (wrap) -> hdr addrs 1022, 1023, 0, 1; data addrs wrap 4095->0 correctly.
- Random dst_export_rdy backpressure and memory rdy stalls, plus rst asserted mid-payload:
  - No flit dropped or duplicated.
  - After rst, all vals are 0 next cycle and the block is READY.
- With LOG_EXPORT_LIMIT_EN, max=2 on a 5-entry log -> 2 entries exported, last set on entry 2.
